// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and glyph table
// for the multi-digit seven-segment driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {IDLE, CONVERT} state_t;

    // Active-low segments, bit0=a .. bit6=g
    function automatic logic [6:0] glyph(input logic [3:0] n);
        unique case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'ha: return 7'b0001000;
            4'hb: return 7'b0000011;
            4'hc: return 7'b1000110;
            4'hd: return 7'b0100001;
            4'he: return 7'b0000110;
            4'hf: return 7'b0001110;
        endcase
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low segment decoder.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = glyph(nibble);

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit hex/decimal display driver with iterative
// double-dabble, leading-zero blanking, overflow and blink.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       value_i,
    input  logic                    load_i,
    input  logic                    mode_bcd_i,
    input  logic                    blank_lz_i,
    input  logic                    blink_en_i,
    output logic                    busy_o,
    output logic [7*NUM_DIGITS-1:0] hex_o
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int AW = 4 * (NUM_DIGITS + 1);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int BW = $clog2(BLINK_DIV);

    state_t            state, state_nx;
    logic [DATA_W-1:0] sr;
    logic [AW-1:0]     acc, acc_adj, acc_nx;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     digits;
    logic              ovf, shown, phase_off;
    logic [BW-1:0]     bcnt;
    logic [DW+DATA_W-1:0] ext;
    logic              start, last;
    logic [6:0]        seg_raw [NUM_DIGITS];

    assign ext   = {{DW{1'b0}}, value_i};
    assign start = load_i && (state == IDLE);
    assign last  = (state == CONVERT) && (cnt == CW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load_i && mode_bcd_i) state_nx = CONVERT;
            CONVERT: if (last) state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == CONVERT);
    end

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    assign acc_nx = AW'({acc_adj, sr[DATA_W-1]});

    always_ff @(posedge clk) begin
        if (reset) begin
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            digits <= '0;
            ovf    <= 1'b0;
            shown  <= 1'b0;
        end else if (start && !mode_bcd_i) begin
            digits <= ext[DW-1:0];
            ovf    <= |ext[DW+DATA_W-1:DW];
            shown  <= 1'b1;
        end else if (start) begin
            sr  <= value_i;
            acc <= '0;
            cnt <= '0;
        end else if (state == CONVERT) begin
            sr  <= sr << 1;
            acc <= acc_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
                digits <= acc_nx[DW-1:0];
                ovf    <= |acc_nx[AW-1:DW];
                shown  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !blink_en_i) begin
            bcnt      <= '0;
            phase_off <= 1'b0;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt      <= '0;
            phase_off <= ~phase_off;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        seg7_glyph u_glyph (
            .nibble(digits[4*g +: 4]),
            .seg   (seg_raw[g])
        );
    end

    // Scan from the top digit so nz marks "a nonzero digit at or above k"
    always_comb begin
        logic nz;
        nz    = 1'b0;
        hex_o = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz = nz | (digits[4*k +: 4] != 4'd0);
            if (!shown || phase_off)
                hex_o[7*k +: 7] = SEG_BLANK;
            else if (ovf)
                hex_o[7*k +: 7] = SEG_DASH;
            else if (blank_lz_i && !nz && k != 0)
                hex_o[7*k +: 7] = SEG_BLANK;
            else
                hex_o[7*k +: 7] = seg_raw[k];
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed self-checking bench for seg7_multi_display
// (4 digits, 14-bit value, blink divider of 4).
module tb_seg7_multi_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load, mode_bcd, blank_lz, blink_en;
    logic        busy;
    logic [27:0] hex;

    int checks = 0;
    int errors = 0;
    int n;

    seg7_multi_display #(
        .NUM_DIGITS(4),
        .DATA_W    (14),
        .BLINK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value_i   (value),
        .load_i    (load),
        .mode_bcd_i(mode_bcd),
        .blank_lz_i(blank_lz),
        .blink_en_i(blink_en),
        .busy_o    (busy),
        .hex_o     (hex)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [27:0] obs,
                         input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] d4(input logic [6:0] a, b, c, e);
        return {a, b, c, e};
    endfunction

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; value = '0; load = 1'b0;
        mode_bcd = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
        tick(); tick(); tick();
        check("rst_hex", hex, '1);
        check("rst_busy", 28'(busy), 28'd0);
        reset = 1'b0;
        tick();
        check("post_rst_hex", hex, '1);

        value = 14'h0A3F; mode_bcd = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("hex_0a3f", hex, d4(G0, GA, G3, GF));
        check("hex_busy", 28'(busy), 28'd0);
        blank_lz = 1'b1;
        #1;
        check("hex_0a3f_lz", hex, d4(BL, GA, G3, GF));
        blank_lz = 1'b0;
        #1;

        value = 14'd9999; mode_bcd = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        check("bcd_busy_start", 28'(busy), 28'd1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                value = 14'd1234; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (n == 5) check("bcd_no_partial", hex, d4(G0, GA, G3, GF));
            tick();
        end
        load = 1'b0;
        check("bcd_busy_len", 28'(n), 28'd14);
        check("bcd_9999", hex, d4(G9, G9, G9, G9));
        tick();
        check("bcd_9999_hold", hex, d4(G9, G9, G9, G9));

        value = 14'd10000; mode_bcd = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle(n);
        check("ovf_len", 28'(n), 28'd14);
        check("ovf_dash", hex, d4(DS, DS, DS, DS));
        value = 14'h3FFF; mode_bcd = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("hex_3fff", hex, d4(G3, GF, GF, GF));

        blank_lz = 1'b1;
        value = 14'd7; mode_bcd = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle(n);
        check("bcd_7_lz", hex, d4(BL, BL, BL, G7));
        blank_lz = 1'b0;
        #1;
        check("bcd_7_nolz", hex, d4(G0, G0, G0, G7));
        blank_lz = 1'b1;
        value = 14'd0; mode_bcd = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("zero_lz", hex, d4(BL, BL, BL, G0));
        blank_lz = 1'b0;
        #1;
        check("zero_nolz", hex, d4(G0, G0, G0, G0));

        value = 14'h1234; mode_bcd = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check("hex_1234", hex, d4(G1, G2, G3, G4));
        blink_en = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            check($sformatf("blink_%0d", i), hex,
                  ((i / 4) % 2 == 1) ? '1 : d4(G1, G2, G3, G4));
        end
        blink_en = 1'b0;
        tick();
        check("blink_off", hex, d4(G1, G2, G3, G4));

        reset = 1'b1; value = 14'h0555; mode_bcd = 1'b0; load = 1'b1;
        tick();
        check("rst_wins", hex, '1);
        reset = 1'b0; load = 1'b0;
        tick();
        check("rst_wins_after", hex, '1);

        value = 14'd9999; mode_bcd = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("mid_busy", 28'(busy), 28'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", 28'(busy), 28'd0);
        check("mid_rst_hex", hex, '1);
        reset = 1'b0;
        tick();
        check("mid_rst_after_busy", 28'(busy), 28'd0);
        check("mid_rst_after_hex", hex, '1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
